// File: rtl/data_mem_responder.sv
// Load/store responder: latches one word request, serves it from an on-chip array after
// LATENCY cycles, and pulses memReady (plus memError on a rejected request).
//
// state | meaning
// IDLE  | waiting for memRead/memWrite; the request is latched on the accept edge
// WAIT  | counting down wait states; requests are ignored
// RESP  | request due; its closing edge commits the access and raises memReady/memError
module data_mem_responder #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          LATENCY    = 1
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] memAddr,
    input  logic [31:0] memDataIn,
    output logic [31:0] memDataOut,
    output logic        memReady,
    output logic        memError
);

    localparam int         DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        wr_q, wr_d;
    logic        both_q, both_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic [32:0]           offset;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  bad;
    logic                  mem_we;

    // A borrow or any offset bit above the array span is out of range, so indices never alias.
    always_comb begin
        offset = {1'b0, addr_q} - {1'b0, BASE_ADDR};
        idx    = offset[ADDR_WIDTH+1:2];
        bad    = both_q
               | (offset[1:0] != 2'b00)
               | offset[32]
               | (offset[31:ADDR_WIDTH+2] != '0);
        mem_we = (state_q == RESP) && wr_q && !bad;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = wr_q;
        both_d  = both_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (memRead || memWrite) begin
                    addr_d = memAddr;
                    data_d = memDataIn;
                    wr_d   = memWrite;
                    both_d = memRead && memWrite;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = LAT_M1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
                err_d   = bad;
                if (!wr_q) begin
                    rdata_d = bad ? 32'h0 : mem[idx];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            data_q  <= 32'h0;
            wr_q    <= 1'b0;
            both_q  <= 1'b0;
            rdata_q <= 32'h0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            both_q  <= both_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Array contents survive reset; an aborted request never reaches RESP, so it never writes.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[idx] <= data_q;
        end
    end

    assign memDataOut = rdata_q;
    assign memReady   = ready_q;
    assign memError   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: three responders (LATENCY 1, 4, 3) share one request bus and are
// checked side by side against hand-computed results.
module tb_data_mem_responder;

    logic        clk_sys;
    logic        rst_b;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] dout [3];
    logic        rdy  [3];
    logic        err  [3];

    int lats [3] = '{1, 4, 3};
    int checks   = 0;
    int failures = 0;
    logic [31:0] out_exp;

    data_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .LATENCY(1)) u_l1 (
        .CLK(clk_sys), .RES(rst_b), .memRead(mem_rd), .memWrite(mem_wr),
        .memAddr(mem_addr), .memDataIn(mem_wdata),
        .memDataOut(dout[0]), .memReady(rdy[0]), .memError(err[0]));

    data_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .LATENCY(4)) u_l4 (
        .CLK(clk_sys), .RES(rst_b), .memRead(mem_rd), .memWrite(mem_wr),
        .memAddr(mem_addr), .memDataIn(mem_wdata),
        .memDataOut(dout[1]), .memReady(rdy[1]), .memError(err[1]));

    data_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .LATENCY(3)) u_l3 (
        .CLK(clk_sys), .RES(rst_b), .memRead(mem_rd), .memWrite(mem_wr),
        .memAddr(mem_addr), .memDataIn(mem_wdata),
        .memDataOut(dout[2]), .memReady(rdy[2]), .memError(err[2]));

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request on the shared bus; every responder must answer exactly LATENCY edges later.
    task automatic do_op(input string tag, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_out);
        int          first  [3];
        int          pulses [3];
        int          stray  [3];
        int          early  [3];
        logic        err_at [3];
        logic [31:0] out_at [3];
        @(negedge clk_sys);
        mem_rd    = rd;
        mem_wr    = wr;
        mem_addr  = addr;
        mem_wdata = wdata;
        @(posedge clk_sys);
        #1;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        for (int d = 0; d < 3; d++) begin
            first[d] = 0; pulses[d] = 0; stray[d] = 0; early[d] = 0;
            err_at[d] = 1'b0; out_at[d] = 32'h0;
        end
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk_sys);
            #1;
            for (int d = 0; d < 3; d++) begin
                if (rdy[d]) begin
                    pulses[d]++;
                    if (first[d] == 0) begin
                        first[d]  = k;
                        err_at[d] = err[d];
                        out_at[d] = dout[d];
                    end
                end else if (err[d]) begin
                    stray[d]++;
                end
                if (first[d] == 0 && dout[d] !== out_exp) early[d]++;
            end
        end
        for (int d = 0; d < 3; d++) begin
            check_val($sformatf("%s_L%0d_latency", tag, lats[d]), 32'(first[d]), 32'(lats[d]));
            check_val($sformatf("%s_L%0d_pulses", tag, lats[d]), 32'(pulses[d]), 32'd1);
            check_val($sformatf("%s_L%0d_err", tag, lats[d]), {31'h0, err_at[d]}, {31'h0, exp_err});
            check_val($sformatf("%s_L%0d_stray_err", tag, lats[d]), 32'(stray[d]), 32'd0);
            check_val($sformatf("%s_L%0d_data", tag, lats[d]), out_at[d], exp_out);
            check_val($sformatf("%s_L%0d_early_data", tag, lats[d]), 32'(early[d]), 32'd0);
        end
        out_exp = exp_out;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int          seen;
        logic [14:0] rdy_mask;
        rst_b     = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        out_exp   = 32'h0;
        #12;
        for (int d = 0; d < 3; d++) begin
            check_val($sformatf("reset_L%0d_ready", lats[d]), {31'h0, rdy[d]}, 32'h0);
            check_val($sformatf("reset_L%0d_err", lats[d]), {31'h0, err[d]}, 32'h0);
            check_val($sformatf("reset_L%0d_data", lats[d]), dout[d], 32'h0);
        end
        @(negedge clk_sys);
        rst_b = 1'b1;

        do_op("wr10",     1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000);
        do_op("rd10",     1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF);
        do_op("wr00",     1'b0, 1'b1, 32'h0000_0000, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF);
        do_op("rd00",     1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1234_5678);
        do_op("rd13_mis", 1'b1, 1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'h0000_0000);
        do_op("wr1000",   1'b0, 1'b1, 32'h0000_1000, 32'hAAAA_5555, 1'b1, 32'h0000_0000);
        do_op("rd00_b",   1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1234_5678);
        do_op("wr20",     1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1'b0, 32'h1234_5678);
        do_op("rdwr20",   1'b1, 1'b1, 32'h0000_0020, 32'h0BAD_BAD0, 1'b1, 32'h1234_5678);
        do_op("rd20",     1'b1, 1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'hCAFE_F00D);
        do_op("wrffc",    1'b0, 1'b1, 32'h0000_0FFC, 32'h5A5A_0FF0, 1'b0, 32'hCAFE_F00D);
        do_op("rdffc",    1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         1'b0, 32'h5A5A_0FF0);
        do_op("rd1000",   1'b1, 1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'h0000_0000);
        do_op("wr40",     1'b0, 1'b1, 32'h0000_0040, 32'h1111_2222, 1'b0, 32'h0000_0000);
        do_op("rd40",     1'b1, 1'b0, 32'h0000_0040, 32'h0,         1'b0, 32'h1111_2222);

        // Reset while the write to 0x40 is still pending in every responder.
        @(negedge clk_sys);
        mem_wr    = 1'b1;
        mem_addr  = 32'h0000_0040;
        mem_wdata = 32'h3333_4444;
        @(posedge clk_sys);
        #1;
        mem_wr = 1'b0;
        rst_b  = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check_val($sformatf("midrst_L%0d_ready", lats[d]), {31'h0, rdy[d]}, 32'h0);
            check_val($sformatf("midrst_L%0d_data", lats[d]), dout[d], 32'h0);
        end
        @(negedge clk_sys);
        @(negedge clk_sys);
        rst_b = 1'b1;
        seen  = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk_sys);
            #1;
            for (int d = 0; d < 3; d++) if (rdy[d]) seen++;
        end
        check_val("midrst_no_ready", 32'(seen), 32'd0);
        out_exp = 32'h0;
        do_op("rd40_after_rst", 1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 32'h1111_2222);

        // memWrite held high; address changes every 5 edges (LATENCY+1 for the L=4 responder).
        rdy_mask = '0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk_sys);
            mem_wr    = 1'b1;
            mem_addr  = 32'h0000_0100 + 32'(4 * (c / 5));
            mem_wdata = 32'hB000_0000 + 32'(c / 5);
            @(posedge clk_sys);
            #1;
            rdy_mask[c] = rdy[1];
        end
        @(negedge clk_sys);
        mem_wr = 1'b0;
        check_val("held_L4_ready_mask", {17'h0, rdy_mask}, 32'h0000_4210);
        repeat (8) @(posedge clk_sys);
        do_op("rd100", 1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 32'hB000_0000);
        do_op("rd104", 1'b1, 1'b0, 32'h0000_0104, 32'h0, 1'b0, 32'hB000_0001);
        do_op("rd108", 1'b1, 1'b0, 32'h0000_0108, 32'h0, 1'b0, 32'hB000_0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
